mem_responder: RTL and testbench

Memory-side responder for the cache line-fill/write-back interface. Accepts one 128-bit line read or write request at a time from an I_cache or D_cache, applies a fixed, programmable access latency, and answers with a single-cycle `mem_ready` pulse. It sits between a cache's memory port and on-chip line storage, and serves as the synthesizable memory model for cache bring-up.

---
 rtl/mem_resp_pkg.sv | 16 +
 rtl/mem_resp_array.sv | 31 +++
 rtl/mem_responder.sv | 164 ++++++++++++++++
 tb/tb_mem_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory-side line responder.
// Holds the FSM state encoding, line/address widths and counter width.
package mem_resp_pkg;

    localparam int LINE_W  = 128;
    localparam int MADDR_W = 28;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_resp_array.sv
// Line storage: 2^DEPTH_LOG2 x LINE_W, one sync write and one sync read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read), rdata (registered). No reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [LINE_W-1:0]     wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one 128-bit line read/write at a time, fixed latency,
// single-cycle mem_ready. Ports: clk, proc_reset_n, mem_read, mem_write, mem_addr,
// mem_wdata, mem_rdata, mem_ready; stat_reads/stat_writes with MEM_RESP_STATS_EN.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic               clk,
    input  logic               proc_reset_n,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [MADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0]  mem_wdata,
    output logic [LINE_W-1:0]  mem_rdata,
    output logic               mem_ready
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]        stat_reads,
    output logic [31:0]        stat_writes
`endif
);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic [LINE_W-1:0]       wdata_q, wdata_d;
    logic                    rvalid_q, rvalid_d;

    logic                    arr_we;
    logic                    arr_re;
    logic [DEPTH_LOG2-1:0]   arr_raddr;
    logic [LINE_W-1:0]       arr_rdata;
    logic                    req;

    // Upper address bits alias onto the same lines.
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[MADDR_W-1:DEPTH_LOG2];

    assign req = mem_read | mem_write;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        rvalid_d  = rvalid_q;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_raddr = addr_q;
        mem_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = mem_addr[DEPTH_LOG2-1:0];
                    wr_d    = mem_write;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        // Latch not yet loaded: read straight from the bus.
                        if (!mem_write) begin
                            arr_re    = 1'b1;
                            arr_raddr = mem_addr[DEPTH_LOG2-1:0];
                            rvalid_d  = 1'b1;
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Counter reaching zero this cycle means RESP is next.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RESP;
                        if (!wr_q) begin
                            arr_re   = 1'b1;
                            rvalid_d = 1'b1;
                        end
                    end
                end
            end
            ST_RESP: begin
                mem_ready = 1'b1;
                arr_we    = wr_q;
                state_d   = ST_GAP;
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    mem_resp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .re    (arr_re),
        .raddr (arr_raddr),
        .rdata (arr_rdata)
    );

    // The array register has no reset; rvalid_q gives the reset value of 0.
    assign mem_rdata = rvalid_q ? arr_rdata : '0;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] stat_reads_q, stat_reads_d;
    logic [31:0] stat_writes_q, stat_writes_d;

    always_comb begin
        stat_reads_d  = stat_reads_q;
        stat_writes_d = stat_writes_q;
        if (state_q == ST_RESP) begin
            if (wr_q) begin
                stat_writes_d = stat_writes_q + 32'd1;
            end else begin
                stat_reads_d = stat_reads_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            stat_reads_q  <= '0;
            stat_writes_q <= '0;
        end else begin
            stat_reads_q  <= stat_reads_d;
            stat_writes_q <= stat_writes_d;
        end
    end

    assign stat_reads  = stat_reads_q;
    assign stat_writes = stat_writes_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a line-array model.
// Optional statistics ports are checked when MEM_RESP_STATS_EN is defined.
module tb_mem_responder;

    localparam int LAT = 4;
    localparam int DL  = 8;

    logic         clk = 1'b0;
    logic         proc_reset_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [27:0]  mem_addr = '0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]  stat_reads;
    logic [31:0]  stat_writes;
`endif

    mem_responder #(
        .LATENCY    (LAT),
        .DEPTH_LOG2 (DL)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
`ifdef MEM_RESP_STATS_EN
        ,
        .stat_reads   (stat_reads),
        .stat_writes  (stat_writes)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] mdl_mem [256];
    logic [127:0] mdl_rd = '0;
    int           mdl_nr = 0;
    int           mdl_nw = 0;
    int           last_ready = 0;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Full transaction starting in IDLE, returns in IDLE after GAP.
    task automatic txn(input logic rd, input logic wr, input logic [27:0] a,
                       input logic [127:0] d);
        int rdy_at = -1;
        int pulses = 0;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        if (wr) begin
            mdl_mem[a[7:0]] = d;
            mdl_nw++;
        end else begin
            mdl_rd = mdl_mem[a[7:0]];
            mdl_nr++;
        end
        for (int c = 0; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                pulses++;
                if (rdy_at < 0) begin
                    rdy_at = c;
                    last_ready = cyc;
                end
            end
            if (c == LAT) check("rdata_resp", mem_rdata, mdl_rd);
            if (c == LAT + 1) check("rdata_gap", mem_rdata, mdl_rd);
            @(posedge clk);
            #1;
            if (c < LAT) begin
                mem_addr  = 28'($urandom());
                mem_wdata = rnd128();
            end else begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        check("ready_cycle", 128'(rdy_at), 128'(LAT));
        check("ready_pulses", 128'(pulses), 128'd1);
    endtask

    // Request dropped at cycle 2 while BUSY; returns in IDLE at cycle 3.
    task automatic abort_txn(input logic rd, input logic wr,
                             input logic [27:0] a, input logic [127:0] d);
        logic seen = 1'b0;
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = d;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_ready) seen = 1'b1;
            if (c == 2) check("abort_rdata", mem_rdata, mdl_rd);
            @(posedge clk);
            #1;
            if (c == 1) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
        end
        check("abort_no_ready", 128'(seen), 128'd0);
    endtask

    task automatic check_stats(input string tag);
`ifdef MEM_RESP_STATS_EN
        check({tag, "_reads"}, 128'(stat_reads), 128'(mdl_nr));
        check({tag, "_writes"}, 128'(stat_writes), 128'(mdl_nw));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        int r0;
        int t0;
        logic [27:0] a;
        repeat (3) @(posedge clk);
        #2 proc_reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", 128'(mem_ready), 128'd0);
        check("reset_rdata", mem_rdata, '0);
        check_stats("reset");

        // Preload and read latency
        txn(0, 1, 28'h05, {4{32'hDEAD_BEEF}});
        txn(1, 0, 28'h05, '0);

        // Write-back then fill, turnaround LAT+2
        txn(0, 1, 28'h12, {16{8'hA5}});
        r0 = last_ready;
        txn(1, 0, 28'h12, '0);
        check("turnaround", 128'(last_ready - r0), 128'(LAT + 2));

        // Abort leaves line unchanged; next request captured right after
        txn(0, 1, 28'h30, {4{32'h1234_5678}});
        abort_txn(0, 1, 28'h30, {4{32'hBAD0_BAD0}});
        txn(1, 0, 28'h30, '0);

        // Read+write together is a write
        txn(0, 1, 28'h07, {4{32'h0707_0707}});
        txn(1, 1, 28'h07, {4{32'hCAFE_F00D}});
        txn(1, 0, 28'h07, '0);

        // Reset in the middle of a write
        mem_write = 1'b1;
        mem_addr  = 28'h12;
        mem_wdata = {4{32'h5555_AAAA}};
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        proc_reset_n = 1'b0;
        #1;
        check("rst_async_ready", 128'(mem_ready), 128'd0);
        check("rst_async_rdata", mem_rdata, '0);
        mem_write = 1'b0;
        mdl_rd = '0;
        mdl_nr = 0;
        mdl_nw = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_held_ready", 128'(mem_ready), 128'd0);
        proc_reset_n = 1'b1;
        @(posedge clk);
        #1;
        txn(1, 0, 28'h12, '0);

        // 3 reads, 2 writes, 1 abort since reset; aliasing 0x100 -> 0x00
        txn(0, 1, 28'h100, {4{32'h0100_0100}});
        txn(1, 0, 28'h000, '0);
        abort_txn(1, 0, 28'h07, '0);
        txn(0, 1, 28'h42, {4{32'h4242_4242}});
        txn(1, 0, 28'h7F_FF42, '0);
        check_stats("stats");

        // Randomized traffic over a small pool of initialized lines
        for (int i = 0; i < 8; i++) begin
            txn(0, 1, 28'(8'h40 + 8'(i)), rnd128());
        end
        for (int i = 0; i < 40; i++) begin
            a = 28'($urandom());
            a[7:0] = 8'h40 + 8'($urandom_range(0, 7));
            t0 = int'($urandom_range(0, 9));
            if (t0 == 0) begin
                abort_txn(1'($urandom()), 1'b1, a, rnd128());
            end else if (t0 < 5) begin
                txn(1, 0, a, '0);
            end else begin
                txn(1'($urandom()), 1, a, rnd128());
            end
        end
        check_stats("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
